// File: rtl/micro_debug_if.sv
// ---------------------------------------------------------------------------
// micro_debug_if
//
// Bundle of run-control, breakpoint, monitor and trace signals between the
// debug front end (buttons / host, the "master") and micro_debug_ctrl
// (the "slave"). Clock and reset are not part of the bundle.
//
// Request semantics: run_req, halt_req, step_req and cnt_clr are single-cycle,
// already-debounced pulses sampled on the rising clock edge. There is no
// ready/acknowledge; a pulse is always consumed in the cycle it is high, and
// a pulse that is not meaningful in the current state is dropped.
//
// Parameters:
//   WIDTH       monitor channel data width
//   NUM_CH      number of monitor channels (>= 2)
//   PC_BITS     core PC / breakpoint address width
//   CNT_BITS    step-count and instruction-counter width
//   TRACE_DEPTH PC trace entries (power of 2, >= 2)
//
// Signals (direction as seen by the slave):
//   in : run_req, halt_req, step_req, step_count, bp_en, bp_addr, core_pc,
//        cnt_clr, sel, mon_ch, trace_idx
//   out: monitor_value, pc_enable, state, bp_hit, instr_count, trace_data
// ---------------------------------------------------------------------------
interface micro_debug_if #(
    parameter int WIDTH       = 16,
    parameter int NUM_CH      = 4,
    parameter int PC_BITS     = 8,
    parameter int CNT_BITS    = 16,
    parameter int TRACE_DEPTH = 8
);
    logic                          run_req;
    logic                          halt_req;
    logic                          step_req;
    logic [CNT_BITS-1:0]           step_count;
    logic                          bp_en;
    logic [PC_BITS-1:0]            bp_addr;
    logic [PC_BITS-1:0]            core_pc;
    logic                          cnt_clr;
    logic [$clog2(NUM_CH)-1:0]     sel;
    logic [NUM_CH*WIDTH-1:0]       mon_ch;
    logic [WIDTH-1:0]              monitor_value;
    logic                          pc_enable;
    logic [1:0]                    state;
    logic                          bp_hit;
    logic [CNT_BITS-1:0]           instr_count;
    logic [$clog2(TRACE_DEPTH)-1:0] trace_idx;
    logic [PC_BITS-1:0]            trace_data;

    modport master (
        output run_req, halt_req, step_req, step_count, bp_en, bp_addr,
               core_pc, cnt_clr, sel, mon_ch, trace_idx,
        input  monitor_value, pc_enable, state, bp_hit, instr_count,
               trace_data
    );

    modport slave (
        input  run_req, halt_req, step_req, step_count, bp_en, bp_addr,
               core_pc, cnt_clr, sel, mon_ch, trace_idx,
        output monitor_value, pc_enable, state, bp_hit, instr_count,
               trace_data
    );
endinterface

// File: rtl/micro_debug_ctrl.sv
// ---------------------------------------------------------------------------
// micro_debug_ctrl
//
// Run-control and monitor block for the micro core.
//   * HALT / RUN / STEP / BREAK state machine producing the core pc_enable
//     (one instruction per high cycle), with multi-instruction stepping,
//     a single PC breakpoint and a saturating executed-instruction counter.
//   * Registered NUM_CH-way monitor mux feeding the display path.
//   * Optional PC trace buffer, built only when MICRO_DBG_TRACE_EN is
//     defined. Without it trace_data is tied to 0 and trace_idx is ignored.
//
// Ports:
//   clk    system clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   dbg    micro_debug_if.slave bundle (requests, breakpoint, core PC,
//          monitor channels/select, trace index in; pc_enable, state,
//          bp_hit, instr_count, monitor_value, trace_data out)
//
// state encoding: 00 HALT, 01 RUN, 10 STEP, 11 BREAK.
// ---------------------------------------------------------------------------
module micro_debug_ctrl #(
    parameter int WIDTH       = 16,
    parameter int NUM_CH      = 4,
    parameter int PC_BITS     = 8,
    parameter int CNT_BITS    = 16,
    parameter int TRACE_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    micro_debug_if.slave    dbg
);

    localparam int SEL_W = $clog2(NUM_CH);
    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } state_t;

    state_t               state_q;
    logic [CNT_BITS-1:0]  remaining_q;
    logic                 skip_q;
    logic                 bp_hit_q;
    logic [CNT_BITS-1:0]  instr_count_q;
    logic [WIDTH-1:0]     monitor_q;
    logic [WIDTH-1:0]     mon_sel;
    logic                 bp_match;
    logic                 pc_enable;

    // skip masks the breakpoint for the first instruction after a resume so
    // the core can leave the breakpoint address before matching re-arms.
    assign bp_match  = dbg.bp_en && (dbg.core_pc == dbg.bp_addr) && !skip_q;

    // Combinational so a breakpoint stops the core before the matching
    // instruction executes.
    assign pc_enable = ((state_q == ST_RUN) && !bp_match) ||
                       ((state_q == ST_STEP) && (remaining_q != '0) && !bp_match);

    // -----------------------------------------------------------------------
    // Run-control state machine
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HALT;
            remaining_q <= '0;
            skip_q      <= 1'b0;
            bp_hit_q    <= 1'b0;
        end else begin
            bp_hit_q <= 1'b0;

            // Cleared by the first executed instruction; a set below (only
            // possible from HALT/BREAK, where pc_enable is low) takes over.
            if (pc_enable) begin
                skip_q <= 1'b0;
            end

            if (dbg.halt_req) begin
                state_q     <= ST_HALT;
                remaining_q <= '0;
            end else if (dbg.run_req && (state_q != ST_RUN)) begin
                // From STEP the remaining step budget is abandoned.
                state_q     <= ST_RUN;
                remaining_q <= '0;
                if (state_q != ST_STEP) begin
                    skip_q <= 1'b1;
                end
            end else if (dbg.step_req &&
                         ((state_q == ST_HALT) || (state_q == ST_BREAK))) begin
                state_q     <= ST_STEP;
                remaining_q <= (dbg.step_count == '0) ? CNT_ONE : dbg.step_count;
                skip_q      <= 1'b1;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (bp_match) begin
                            state_q  <= ST_BREAK;
                            bp_hit_q <= 1'b1;
                        end
                    end
                    ST_STEP: begin
                        if (bp_match) begin
                            // remaining is left as-is; a later run or step
                            // request overwrites it.
                            state_q  <= ST_BREAK;
                            bp_hit_q <= 1'b1;
                        end else if (remaining_q == '0) begin
                            state_q <= ST_HALT;
                        end else begin
                            remaining_q <= remaining_q - CNT_ONE;
                            if (remaining_q == CNT_ONE) begin
                                state_q <= ST_HALT;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Executed-instruction counter (saturating, clear has priority)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count_q <= '0;
        end else if (dbg.cnt_clr) begin
            instr_count_q <= '0;
        end else if (pc_enable && (instr_count_q != '1)) begin
            instr_count_q <= instr_count_q + CNT_ONE;
        end
    end

    // -----------------------------------------------------------------------
    // Monitor mux: an out-of-range select matches no channel and yields 0.
    // -----------------------------------------------------------------------
    always_comb begin
        mon_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (dbg.sel == k[SEL_W-1:0]) begin
                mon_sel = dbg.mon_ch[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            monitor_q <= '0;
        end else begin
            monitor_q <= mon_sel;
        end
    end

    // -----------------------------------------------------------------------
    // Optional PC trace buffer
    // -----------------------------------------------------------------------
`ifdef MICRO_DBG_TRACE_EN
    localparam int IDX_W = $clog2(TRACE_DEPTH);
    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    logic [PC_BITS-1:0] trace_mem [TRACE_DEPTH];
    logic [IDX_W-1:0]   wr_ptr_q;   // slot the next executed PC goes into
    logic [IDX_W-1:0]   rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            for (int i = 0; i < TRACE_DEPTH; i++) begin
                trace_mem[i] <= '0;
            end
        end else if (pc_enable) begin
            trace_mem[wr_ptr_q] <= dbg.core_pc;
            wr_ptr_q            <= wr_ptr_q + IDX_ONE;
        end
    end

    // Index 0 is the most recent write; TRACE_DEPTH is a power of two so
    // the subtraction wraps naturally around the ring.
    assign rd_ptr         = wr_ptr_q - dbg.trace_idx - IDX_ONE;
    assign dbg.trace_data = trace_mem[rd_ptr];
`else
    localparam int TRACE_DEPTH_UNUSED = TRACE_DEPTH;
    logic unused_trace_idx;

    assign unused_trace_idx = ^dbg.trace_idx;
    assign dbg.trace_data   = '0;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign dbg.pc_enable     = pc_enable;
    assign dbg.state         = state_q;
    assign dbg.bp_hit        = bp_hit_q;
    assign dbg.instr_count   = instr_count_q;
    assign dbg.monitor_value = monitor_q;

endmodule

// File: doc/micro_debug_ctrl.md
Name: micro_debug_ctrl

Overview:
- Parametrised run-control and monitor block for the micro core, replacing fixed button-driven PC enable and the 4-way monitor mux.
- Generates the core's pc_enable from a HALT/RUN/STEP/BREAK state machine, with multi-instruction stepping, a PC breakpoint and a saturating executed-instruction counter.
- Provides an N-channel registered monitor mux to the display path.
- Requests arrive as already-debounced single-cycle pulses.

Parameters:
- WIDTH, 16, monitor channel data width
- NUM_CH, 4, number of monitor channels (>=2)
- PC_BITS, 8, core PC / breakpoint address width
- CNT_BITS, 16, step-count and instruction-counter width
- TRACE_DEPTH, 8, PC trace entries (power of 2, >=2); used only with the optional feature

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- run_req  in  1  pulse: free-run
- halt_req  in  1  pulse: stop
- step_req  in  1  pulse: execute step_count instructions
- step_count  in  CNT_BITS  instructions per step request; 0 is treated as 1
- bp_en  in  1  breakpoint enable
- bp_addr  in  PC_BITS  breakpoint PC
- core_pc  in  PC_BITS  current core PC
- cnt_clr  in  1  synchronous clear of instr_count
- sel  in  $clog2(NUM_CH)  monitor channel select
- mon_ch  in  NUM_CH*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH]
- monitor_value  out  WIDTH  registered selected channel
- pc_enable  out  1  core advance enable, one instruction per high cycle
- state  out  2  00 HALT, 01 RUN, 10 STEP, 11 BREAK
- bp_hit  out  1  single-cycle pulse on entry to BREAK
- instr_count  out  CNT_BITS  saturating count of pc_enable cycles
- trace_idx  in  $clog2(TRACE_DEPTH)  trace read index; 0 = most recent
- trace_data  out  PC_BITS  trace read data

Behaviour:
- Reset values (asynchronous, rst_n=0): state=HALT, remaining=0, skip=0, instr_count=0, monitor_value=0, bp_hit=0, pc_enable=0, trace entries=0.
- Reset mid-operation aborts any run or step immediately.
- bp_match = bp_en && core_pc==bp_addr && !skip.
- pc_enable is combinational:
  - (state==RUN && !bp_match), or
  - (state==STEP && remaining!=0 && !bp_match).
- Request priority in the same cycle: halt_req > run_req > step_req.
- halt_req: any state -> HALT; remaining <= 0.
- run_req: from HALT or BREAK -> RUN, skip <= 1. Ignored in RUN. In STEP, the step is abandoned (remaining <= 0) and the block goes to RUN.
- step_req: from HALT or BREAK -> STEP, remaining <= (step_count==0 ? 1 : step_count), skip <= 1. Ignored in RUN and STEP.
- RUN: if bp_match -> BREAK with bp_hit=1 for one cycle; otherwise stay.
- STEP:
  - bp_match -> BREAK with bp_hit pulse; remaining is kept but unused.
  - Each pc_enable cycle decrements remaining.
  - pc_enable with remaining==1 -> HALT on the next edge.
- skip clears on the first pc_enable cycle after being set. Resuming from a breakpoint therefore executes the breakpoint instruction once before matching is re-armed.
- instr_count:
  - +1 on each pc_enable cycle, saturating at all-ones.
  - cnt_clr has priority over increment; instr_count reads 0 on the next cycle.
- Monitor: monitor_value <= (sel < NUM_CH) ? mon_ch[sel] : 0. Latency 1 cycle.
- bp_en or bp_addr changing while in RUN takes effect on the next compare cycle.

Optional Feature:
- Macro: MICRO_DBG_TRACE_EN.
- Defined: circular buffer of TRACE_DEPTH PC values.
  - core_pc is written on every pc_enable cycle; the write pointer wraps.
  - trace_data = entry written trace_idx writes ago, combinational read.
  - Entries not yet written read 0.
- Not defined: no buffer is built; trace_data is tied to 0; trace_idx is unused.

Test Plan:
- Reset and idle: rst_n low, then high, no requests -> state=00, pc_enable=0, instr_count=0, monitor_value=0.
- Multi-step: step_count=5, step_req pulse -> exactly 5 pc_enable cycles, then state=00, instr_count=5.
- Zero step count: step_count=0, step_req -> 1 pc_enable cycle.
- Breakpoint and resume: bp_en=1, bp_addr=0x10, core_pc incrementing from 0x0C, run_req:
  - pc_enable is low when core_pc=0x10; state=11; bp_hit pulses once.
  - A following run_req -> pc_enable high at PC 0x10, core continues; with a looping PC the breakpoint re-hits.
- Priority: halt_req and run_req in the same cycle while HALT -> stays 00. halt_req during STEP with remaining=3 -> HALT next cycle, no further pc_enable.
- Monitor and counter edges:
  - NUM_CH=4, sel=2, mon_ch[2]=0xBEEF -> monitor_value=0xBEEF one cycle later.
  - CNT_BITS=4, 20 runs of pc_enable -> instr_count holds 0xF.
  - cnt_clr -> instr_count=0.
  - With MICRO_DBG_TRACE_EN, after PCs 1..10 with depth 8: trace_idx=0 -> 10, trace_idx=7 -> 3.
